srt4_div_arbiter: RTL and testbench

Round-robin scheduler that shares one SRT-4 radix-4 divider (the CU + datapath pair, beginSignal/endSignal handshake) between NREQ requesters. It latches the winning requester's operands and sequences the divider's begin pulse. It captures quotient/remainder on the end pulse and returns them to the owning requester. It also short-circuits divide-by-zero and aborts a hung divider via a watchdog.

---
 rtl/srt4_pkg.sv | 18 +
 rtl/srt4_div_arbiter_rr_pick.sv | 30 +++
 rtl/srt4_div_arbiter.sv | 160 ++++++++++++++++
 tb/tb_srt4_div_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/srt4_pkg.sv
// Shared constants for the SRT-4 divider arbiter family.
package srt4_pkg;

    // Native width of the shared SRT-4 divider.
    localparam int unsigned DIV_W = 8;

    // Scheduler FSM state encoding.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    // Divide-by-zero result: quotient saturates to all ones, error flagged.
    localparam logic DZ_Q_FILL = 1'b1;
    localparam logic DZ_ERR    = 1'b1;

endpackage

// File: rtl/srt4_div_arbiter_rr_pick.sv
// Combinational N-wide circular priority picker, searching from ptr+1.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk offsets from farthest to nearest so the closest requester after ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned off = N; off >= 1; off--) begin
            int unsigned c;
            c = (int'(ptr) + off) % N;
            if (req[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = IW'(c);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/srt4_div_arbiter.sv
// Round-robin scheduler sharing one SRT-4 divider between NREQ requesters.
module srt4_div_arbiter
    import srt4_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = DIV_W,
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned TW      = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     resp_valid,
    input  logic [NREQ-1:0]     resp_ready,
    output logic [W-1:0]        resp_q,
    output logic [W-1:0]        resp_r,
    output logic                resp_err,
    output logic                div_begin,
    output logic                div_rst_b,
    output logic [W-1:0]        div_a,
    output logic [W-1:0]        div_b,
    input  logic                div_end,
    input  logic [W-1:0]        div_q,
    input  logic [W-1:0]        div_r
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [2:0]      state, state_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n;
    logic [IW-1:0]   owner, owner_n;
    logic [TW-1:0]   watchdog, watchdog_n;
    logic [NREQ-1:0] resp_valid_n;
    logic [W-1:0]    resp_q_n, resp_r_n, div_a_n, div_b_n;
    logic            resp_err_n, div_begin_n, div_rst_b_n;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [W-1:0]    sel_a, sel_b;
    logic [NREQ-1:0] owner_oh;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Operands of the candidate winner and the current owner's one-hot.
    assign sel_a    = req_a[pick_idx*W +: W];
    assign sel_b    = req_b[pick_idx*W +: W];
    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;

    // Accept is only offered while idle.
    assign req_ready = (state == S_IDLE) ? pick_grant : '0;

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        owner_n      = owner;
        watchdog_n   = watchdog;
        resp_valid_n = resp_valid;
        resp_q_n     = resp_q;
        resp_r_n     = resp_r;
        resp_err_n   = resp_err;
        div_a_n      = div_a;
        div_b_n      = div_b;
        div_begin_n  = 1'b0;
        div_rst_b_n  = 1'b1;
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    owner_n  = pick_idx;
                    rr_ptr_n = pick_idx;
                    div_a_n  = sel_a;
                    div_b_n  = sel_b;
                    if (sel_b == '0) begin
                        resp_q_n     = {W{DZ_Q_FILL}};
                        resp_r_n     = sel_a;
                        resp_err_n   = DZ_ERR;
                        resp_valid_n = pick_grant;
                        state_n      = S_RESP;
                    end else begin
                        div_begin_n = 1'b1;
                        state_n     = S_START;
                    end
                end
            end
            S_START: begin
                watchdog_n = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                watchdog_n = watchdog + 1'b1;
                if (div_end) begin
                    resp_q_n     = div_q;
                    resp_r_n     = div_r;
                    resp_err_n   = 1'b0;
                    resp_valid_n = owner_oh;
                    state_n      = S_RESP;
                end else if (watchdog == TW'(TIMEOUT)) begin
                    resp_q_n    = '0;
                    resp_r_n    = '0;
                    resp_err_n  = 1'b1;
                    div_rst_b_n = 1'b0;
                    state_n     = S_ABORT;
                end
            end
            S_ABORT: begin
                resp_valid_n = owner_oh;
                state_n      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready[owner]) begin
                    resp_valid_n = '0;
                    state_n      = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= IW'(NREQ - 1);
            owner      <= '0;
            watchdog   <= '0;
            resp_valid <= '0;
            resp_q     <= '0;
            resp_r     <= '0;
            resp_err   <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            div_begin  <= 1'b0;
            div_rst_b  <= 1'b1;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            owner      <= owner_n;
            watchdog   <= watchdog_n;
            resp_valid <= resp_valid_n;
            resp_q     <= resp_q_n;
            resp_r     <= resp_r_n;
            resp_err   <= resp_err_n;
            div_a      <= div_a_n;
            div_b      <= div_b_n;
            div_begin  <= div_begin_n;
            div_rst_b  <= div_rst_b_n;
        end
    end

endmodule

// File: tb/tb_srt4_div_arbiter.sv
// Directed bench for srt4_div_arbiter with a behavioural fixed-latency divider.
module tb_srt4_div_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int LAT  = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [W-1:0]    resp_q, resp_r, div_a, div_b, div_q, div_r;
    logic            resp_err, div_begin, div_rst_b, div_end;

    // Divider model state
    logic            hang, stray_end, m_end, busy;
    logic [W-1:0]    ma, mb, mq, mr;
    int              mcnt;

    int ncmp  = 0;
    int nfail = 0;

    srt4_div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(63), .TW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_q     (resp_q),
        .resp_r     (resp_r),
        .resp_err   (resp_err),
        .div_begin  (div_begin),
        .div_rst_b  (div_rst_b),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_end    (div_end),
        .div_q      (div_q),
        .div_r      (div_r)
    );

    always #5 clk = ~clk;

    assign div_end = m_end | stray_end;
    assign div_q   = stray_end ? 8'hAA : mq;
    assign div_r   = stray_end ? 8'h55 : mr;

    // Divider: end pulse LAT cycles after the begin cycle unless hung.
    always @(posedge clk) begin
        m_end <= 1'b0;
        if (rst || !div_rst_b) begin
            busy <= 1'b0;
        end else if (div_begin) begin
            busy <= 1'b1;
            mcnt <= 1;
            ma   <= div_a;
            mb   <= div_b;
        end else if (busy) begin
            mcnt <= mcnt + 1;
            if (mcnt == LAT - 1 && !hang) begin
                m_end <= 1'b1;
                busy  <= 1'b0;
                mq    <= ma / mb;
                mr    <= ma % mb;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int k;
        int gidx [5];
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
        hang = 1'b0; stray_end = 1'b0; busy = 1'b0; mcnt = 0;
        ma = '0; mb = 8'd1; mq = '0; mr = '0; m_end = 1'b0;
        cyc(); cyc();
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_div_rst_b", 32'(div_rst_b), 1);
        chk("rst_div_begin", 32'(div_begin), 0);
        chk("rst_resp_q", 32'(resp_q), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        cyc();

        // Single op: requester 2, 100/7
        req_a[16 +: 8] = 8'd100; req_b[16 +: 8] = 8'd7; req_valid = 4'b0100;
        #1;
        chk("op_req_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        #1;
        chk("op_begin", 32'(div_begin), 1);
        chk("op_ready_busy", 32'(req_ready), 0);
        chk("op_div_a", 32'(div_a), 100);
        chk("op_div_b", 32'(div_b), 7);
        n = 1;
        while (resp_valid == '0 && n < 100) begin cyc(); n++; end
        chk("op_latency", 32'(n), 22);
        chk("op_resp_valid", 32'(resp_valid), 32'h4);
        chk("op_q", 32'(resp_q), 14);
        chk("op_r", 32'(resp_r), 2);
        chk("op_err", 32'(resp_err), 0);

        // Backpressure with foreign resp_ready bits and a stray end pulse
        req_valid = 4'b0001; resp_ready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            stray_end = (i == 2);
            #1;
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_resp_valid", 32'(resp_valid), 32'h4);
            chk("bp_q", 32'(resp_q), 14);
            chk("bp_r", 32'(resp_r), 2);
            cyc();
        end
        stray_end = 1'b0; req_valid = '0; resp_ready = 4'b0100;
        cyc();
        chk("bp_release", 32'(resp_valid), 0);
        resp_ready = '0;

        // Divide by zero: requester 1, 55/0
        req_a[8 +: 8] = 8'd55; req_b[8 +: 8] = 8'd0; req_valid = 4'b0010;
        #1;
        chk("dz_req_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        #1;
        chk("dz_resp_valid", 32'(resp_valid), 32'h2);
        chk("dz_q", 32'(resp_q), 32'hFF);
        chk("dz_r", 32'(resp_r), 55);
        chk("dz_err", 32'(resp_err), 1);
        chk("dz_no_begin", 32'(div_begin), 0);
        resp_ready = 4'b0010;
        cyc();
        chk("dz_release", 32'(resp_valid), 0);
        chk("dz_still_no_begin", 32'(div_begin), 0);
        resp_ready = '0;

        // Timeout: hung divider, requester 3, 9/3
        hang = 1'b1;
        req_a[24 +: 8] = 8'd9; req_b[24 +: 8] = 8'd3; req_valid = 4'b1000;
        #1;
        chk("to_req_ready", 32'(req_ready), 32'h8);
        cyc();
        req_valid = '0;
        chk("to_begin", 32'(div_begin), 1);
        n = 0;
        while (div_rst_b && n < 200) begin cyc(); n++; end
        chk("to_window", 32'(n >= 64 && n <= 65), 1);
        chk("to_rst_b_low", 32'(div_rst_b), 0);
        cyc();
        chk("to_rst_b_one_cycle", 32'(div_rst_b), 1);
        chk("to_resp_valid", 32'(resp_valid), 32'h8);
        chk("to_err", 32'(resp_err), 1);
        chk("to_q", 32'(resp_q), 0);
        chk("to_r", 32'(resp_r), 0);
        resp_ready = 4'b1000;
        cyc();
        chk("to_release", 32'(resp_valid), 0);
        resp_ready = '0; hang = 1'b0;

        // Recovery op: requester 0, 200/9
        req_a[0 +: 8] = 8'd200; req_b[0 +: 8] = 8'd9; req_valid = 4'b0001;
        #1;
        chk("rec_req_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        n = 1;
        while (resp_valid == '0 && n < 100) begin cyc(); n++; end
        chk("rec_latency", 32'(n), 22);
        chk("rec_q", 32'(resp_q), 22);
        chk("rec_r", 32'(resp_r), 2);
        chk("rec_err", 32'(resp_err), 0);
        resp_ready = 4'b0001;
        cyc();
        resp_ready = '0;

        // Reset in the middle of WAIT: requester 2, 50/5
        req_a[16 +: 8] = 8'd50; req_b[16 +: 8] = 8'd5; req_valid = 4'b0100;
        cyc();
        req_valid = '0;
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1;
        cyc();
        chk("mr_resp_valid", 32'(resp_valid), 0);
        chk("mr_div_a", 32'(div_a), 0);
        chk("mr_div_b", 32'(div_b), 0);
        chk("mr_begin", 32'(div_begin), 0);
        chk("mr_rst_b", 32'(div_rst_b), 1);
        chk("mr_q", 32'(resp_q), 0);
        chk("mr_r", 32'(resp_r), 0);
        chk("mr_err", 32'(resp_err), 0);
        rst = 1'b0;

        // Fairness: everyone valid, responses accepted immediately
        req_a = {8'd33, 8'd32, 8'd31, 8'd30};
        req_b = {8'd3, 8'd3, 8'd3, 8'd3};
        req_valid = 4'b1111; resp_ready = 4'b1111;
        #1;
        k = 0; n = 0;
        while (k < 5 && n < 1000) begin
            if (req_ready != '0) begin
                gidx[k] = -1;
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) gidx[k] = j;
                k++;
            end
            cyc();
            n++;
        end
        chk("fair_count", 32'(k), 5);
        for (int j = 0; j < 5; j++) begin
            if (j < k) chk($sformatf("fair_grant%0d", j), 32'(gidx[j]), 32'(exp_order[j]));
        end
        req_valid = '0; resp_ready = '0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
